// File: rtl/neogeo_sys_pkg.sv
// Shared constants and types for the 68k system-register write strobe front-end.
package neogeo_sys_pkg;

  localparam logic [6:0] REG0_A23_17 = 7'h1C;
  localparam logic [6:0] REG1_A23_17 = 7'h1D;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_e;

  typedef enum logic {TGT_BITW0, TGT_BITW1} target_e;

endpackage

// File: rtl/sysreg_write_strobe_if.sv
// 68k-side bus bundle for the system-register write strobe block.
interface sysreg_write_strobe_if;

  logic [23:1] M68K_ADDR;
  logic        M68K_RW;
  logic        nAS;
  logic        nLDS;
  logic        nUDS;
  logic [3:0]  LATCH_ADDR;
  logic        nBITW0;
  logic        nBITW1;
  logic        nDTACK_REG;

  modport master (
    output M68K_ADDR, M68K_RW, nAS, nLDS, nUDS,
    input  LATCH_ADDR, nBITW0, nBITW1, nDTACK_REG
  );

  modport slave (
    input  M68K_ADDR, M68K_RW, nAS, nLDS, nUDS,
    output LATCH_ADDR, nBITW0, nBITW1, nDTACK_REG
  );

endinterface

// File: rtl/sync_ff.sv
// Multi-stage synchroniser; resets to 1 so an active-low strobe reads as idle.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/sysreg_write_strobe.sv
// 68k byte-write decoder for $380000-$3BFFFF: fixed-length nBITW0/nBITW1 strobe, then nDTACK.
module sysreg_write_strobe
  import neogeo_sys_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STROBE_LEN  = 2
) (
  input  logic                  CLK_24M,
  input  logic                  nRESET,
  sysreg_write_strobe_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(STROBE_LEN + 1);

  logic             w_as_s;
  logic             w_lds_s;
  logic             w_uds_s;
  logic [SYNC_STAGES-1:0] r_prime;
  logic             r_as_prev;
  logic             w_start;
  logic             w_reg0;
  logic             w_reg1;
  state_e           r_state;
  state_e           w_state_d;
  target_e          r_target;
  target_e          w_target_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic [3:0]       r_latch_addr;
  logic [3:0]       w_latch_addr_d;
  logic             r_nbitw0;
  logic             r_nbitw1;
  logic             r_ndtack;
  logic             w_nbitw0_d;
  logic             w_nbitw1_d;
  logic             w_ndtack_d;
  logic             w_unused;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_as (
    .i_clk   (CLK_24M),
    .i_rst_n (nRESET),
    .i_d     (bus.nAS),
    .o_q     (w_as_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lds (
    .i_clk   (CLK_24M),
    .i_rst_n (nRESET),
    .i_d     (bus.nLDS),
    .o_q     (w_lds_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_uds (
    .i_clk   (CLK_24M),
    .i_rst_n (nRESET),
    .i_d     (bus.nUDS),
    .o_q     (w_uds_s)
  );

  // Only lower-strobe presence matters for the decode; the upper strobe is synchronised for parity.
  assign w_unused = ^{bus.M68K_ADDR[16:5], w_uds_s};

  // as_prev is held at 0 until the synchroniser holds real samples, so the reset-to-1 flops
  // cannot fake a falling edge when nAS is already low at reset release.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      r_prime   <= '0;
      r_as_prev <= 1'b0;
    end else begin
      r_prime   <= {r_prime[SYNC_STAGES-2:0], 1'b1};
      r_as_prev <= r_prime[SYNC_STAGES-1] & w_as_s;
    end
  end

  assign w_start = r_as_prev & ~w_as_s;
  assign w_reg0  = (bus.M68K_ADDR[23:17] == REG0_A23_17);
  assign w_reg1  = (bus.M68K_ADDR[23:17] == REG1_A23_17);

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      r_state      <= IDLE;
      r_target     <= TGT_BITW0;
      r_cnt        <= '0;
      r_latch_addr <= 4'b0000;
      r_nbitw0     <= 1'b1;
      r_nbitw1     <= 1'b1;
      r_ndtack     <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_target     <= w_target_d;
      r_cnt        <= w_cnt_d;
      r_latch_addr <= w_latch_addr_d;
      r_nbitw0     <= w_nbitw0_d;
      r_nbitw1     <= w_nbitw1_d;
      r_ndtack     <= w_ndtack_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_target_d     = r_target;
    w_cnt_d        = r_cnt;
    w_latch_addr_d = r_latch_addr;
    unique case (r_state)
      IDLE: begin
        if (w_start && (w_reg0 || w_reg1) && !bus.M68K_RW) begin
          if (!w_lds_s) begin
            w_latch_addr_d = bus.M68K_ADDR[4:1];
            w_target_d     = w_reg1 ? TGT_BITW1 : TGT_BITW0;
            w_state_d      = SETUP;
          end else begin
            w_state_d = ACK;
          end
        end
      end
      SETUP: begin
        w_cnt_d   = CNT_W'(STROBE_LEN - 1);
        w_state_d = STROBE;
      end
      STROBE: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end else if (w_as_s) begin
          w_state_d = IDLE;
        end else begin
          w_state_d = ACK;
        end
      end
      ACK: begin
        if (w_as_s) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    w_nbitw0_d = 1'b1;
    w_nbitw1_d = 1'b1;
    w_ndtack_d = 1'b1;
    if (w_state_d == STROBE) begin
      w_nbitw0_d = (w_target_d != TGT_BITW0);
      w_nbitw1_d = (w_target_d != TGT_BITW1);
    end
    if (w_state_d == ACK) begin
      w_ndtack_d = 1'b0;
    end
  end

  assign bus.LATCH_ADDR = r_latch_addr;
  assign bus.nBITW0     = r_nbitw0;
  assign bus.nBITW1     = r_nbitw1;
  assign bus.nDTACK_REG = r_ndtack;

endmodule

// File: tb/tb_sysreg_write_strobe.sv
// Drives three strobe-length variants in lockstep and checks every cycle against a timing model.
module tb_sysreg_write_strobe;

  localparam int S    = 2;
  localparam int ND   = 3;
  localparam int MAXC = 4096;

  logic        clk  = 1'b0;
  logic        nrst = 1'b1;
  logic [23:1] a;
  logic        rw;
  logic        nas;
  logic        nlds;
  logic        nuds;

  sysreg_write_strobe_if bus0 ();
  sysreg_write_strobe_if bus1 ();
  sysreg_write_strobe_if bus2 ();

  assign bus0.M68K_ADDR = a;
  assign bus0.M68K_RW   = rw;
  assign bus0.nAS       = nas;
  assign bus0.nLDS      = nlds;
  assign bus0.nUDS      = nuds;
  assign bus1.M68K_ADDR = a;
  assign bus1.M68K_RW   = rw;
  assign bus1.nAS       = nas;
  assign bus1.nLDS      = nlds;
  assign bus1.nUDS      = nuds;
  assign bus2.M68K_ADDR = a;
  assign bus2.M68K_RW   = rw;
  assign bus2.nAS       = nas;
  assign bus2.nLDS      = nlds;
  assign bus2.nUDS      = nuds;

  sysreg_write_strobe #(.SYNC_STAGES(2), .STROBE_LEN(2)) u_dut0 (
    .CLK_24M (clk),
    .nRESET  (nrst),
    .bus     (bus0)
  );

  sysreg_write_strobe #(.SYNC_STAGES(2), .STROBE_LEN(1)) u_dut1 (
    .CLK_24M (clk),
    .nRESET  (nrst),
    .bus     (bus1)
  );

  sysreg_write_strobe #(.SYNC_STAGES(2), .STROBE_LEN(4)) u_dut2 (
    .CLK_24M (clk),
    .nRESET  (nrst),
    .bus     (bus2)
  );

  logic [3:0] o_la [ND];
  logic       o_b0 [ND];
  logic       o_b1 [ND];
  logic       o_dt [ND];

  assign o_la[0] = bus0.LATCH_ADDR;
  assign o_la[1] = bus1.LATCH_ADDR;
  assign o_la[2] = bus2.LATCH_ADDR;
  assign o_b0[0] = bus0.nBITW0;
  assign o_b0[1] = bus1.nBITW0;
  assign o_b0[2] = bus2.nBITW0;
  assign o_b1[0] = bus0.nBITW1;
  assign o_b1[1] = bus1.nBITW1;
  assign o_b1[2] = bus2.nBITW1;
  assign o_dt[0] = bus0.nDTACK_REG;
  assign o_dt[1] = bus1.nDTACK_REG;
  assign o_dt[2] = bus2.nDTACK_REG;

  // Expected output level after each rising edge, indexed by edge number.
  logic       exp_b0 [ND][MAXC];
  logic       exp_b1 [ND][MAXC];
  logic       exp_dt [ND][MAXC];
  logic [3:0] exp_la [MAXC];

  int cyc;
  int rise_at;
  int n_tests;
  int n_fail;

  always #5 clk = ~clk;

  function automatic int len_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string tag, input int d, input logic [3:0] got, input logic [3:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s dut%0d cyc%0d: got %h want %h", tag, d, cyc, got, want);
    end
  endtask

  task automatic check_all(input int c);
    for (int d = 0; d < ND; d++) begin
      chk("latch_addr", d, o_la[d], exp_la[c]);
      chk("nbitw0", d, {3'b000, o_b0[d]}, {3'b000, exp_b0[d][c]});
      chk("nbitw1", d, {3'b000, o_b1[d]}, {3'b000, exp_b1[d][c]});
      chk("ndtack", d, {3'b000, o_dt[d]}, {3'b000, exp_dt[d][c]});
      chk("no_overlap", d, {3'b000, o_b0[d] | o_b1[d]}, 4'h1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (cyc >= MAXC - 64) begin
      $display("FAIL cycle_budget: got cyc %0d want < %0d", cyc, MAXC - 64);
      $fatal(1, "cycle budget exhausted");
    end
    check_all(cyc);
    if (cyc == rise_at) begin
      nas  = 1'b1;
      nlds = 1'b1;
      nuds = 1'b1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fill_idle(input int from);
    for (int k = from; k < MAXC; k++) begin
      exp_la[k] = 4'h0;
      for (int d = 0; d < ND; d++) begin
        exp_b0[d][k] = 1'b1;
        exp_b1[d][k] = 1'b1;
        exp_dt[d][k] = 1'b1;
      end
    end
  endtask

  // Timing rules: strobe low on edges f+S+2 .. f+S+1+L; the strobe-end edge aborts when the
  // nAS rise has crossed the synchroniser, i.e. hold <= L+1; DTACK releases S+1 edges after nAS rise.
  task automatic start_txn(input logic [23:0] ba, input logic w_rw, input logic w_lds,
                           input logic w_uds, input int hold);
    int         f;
    logic [6:0] rg;
    bit         hit;
    f    = cyc;
    rg   = ba[23:17];
    hit  = (rg == 7'h1C) || (rg == 7'h1D);
    a    = ba[23:1];
    rw   = w_rw;
    nlds = w_lds;
    nuds = w_uds;
    nas  = 1'b0;
    rise_at = f + hold;
    if (hit && !w_rw && !w_lds) begin
      for (int k = f + S + 1; k < MAXC; k++) exp_la[k] = ba[4:1];
      for (int d = 0; d < ND; d++) begin
        int l;
        l = len_of(d);
        for (int c = f + S + 2; c <= f + S + 1 + l; c++) begin
          if (rg == 7'h1D) exp_b1[d][c] = 1'b0;
          else             exp_b0[d][c] = 1'b0;
        end
        if (hold > l + 1) begin
          for (int c = f + S + 2 + l; c <= f + hold + S; c++) exp_dt[d][c] = 1'b0;
        end
      end
    end else if (hit && !w_rw) begin
      for (int d = 0; d < ND; d++) begin
        for (int c = f + S + 1; c <= f + hold + S; c++) exp_dt[d][c] = 1'b0;
      end
    end
  endtask

  task automatic txn(input logic [23:0] ba, input logic w_rw, input logic w_lds,
                     input logic w_uds, input int hold);
    start_txn(ba, w_rw, w_lds, w_uds, hold);
    ticks(hold + 12);
  endtask

  initial begin
    logic [23:0] ba;
    logic        r_rw;
    logic        r_lds;
    logic        r_uds;
    int          hold;
    int          sel;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rise_at = -1;
    a       = '0;
    rw      = 1'b1;
    nas     = 1'b1;
    nlds    = 1'b1;
    nuds    = 1'b1;
    fill_idle(0);

    #1 nrst = 1'b0;
    #1 check_all(0);
    ticks(3);
    nrst = 1'b1;
    ticks(4);

    // Directed: system latch, output latch, ignored cycles, upper-byte-only ack.
    txn(24'h3A0011, 1'b0, 1'b0, 1'b1, 8);
    txn(24'h380001, 1'b0, 1'b0, 1'b1, 8);
    txn(24'h3A0011, 1'b1, 1'b0, 1'b1, 6);
    txn(24'h3C0001, 1'b0, 1'b0, 1'b1, 6);
    txn(24'h3A0010, 1'b0, 1'b1, 1'b0, 6);
    txn(24'h38001E, 1'b0, 1'b0, 1'b0, 9);

    // Reset in the middle of a strobe, released with nAS still low.
    start_txn(24'h3A0011, 1'b0, 1'b0, 1'b1, 30);
    ticks(5);
    nrst = 1'b0;
    #1;
    fill_idle(cyc);
    check_all(cyc);
    fill_idle(cyc + 1);
    ticks(3);
    nrst = 1'b1;
    ticks(30);
    txn(24'h3A0015, 1'b0, 1'b0, 1'b1, 8);

    // nAS released early: abort threshold differs per strobe length.
    for (int h = 1; h <= 6; h++) begin
      txn(24'h3A0003, 1'b0, 1'b0, 1'b1, h);
      txn(24'h380019, 1'b0, 1'b0, 1'b1, h);
    end

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      ba  = {$urandom} & 24'h01FFFF;
      case (sel)
        0:       ba[23:17] = 7'h1C;
        1:       ba[23:17] = 7'h1D;
        2:       ba[23:17] = 7'h1D;
        default: ba[23:17] = 7'h1E;
      endcase
      r_rw  = ($urandom_range(0, 4) == 0);
      r_lds = $urandom_range(0, 2) == 0;
      r_uds = r_lds ? 1'b0 : 1'($urandom_range(0, 1));
      hold  = $urandom_range(1, 10);
      txn(ba, r_rw, r_lds, r_uds, hold);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
